brc_iter: RTL and testbench

BRC_ITER -- requirements
Module: brc_iter

---
 rtl/brc_iter.sv | 133 +++++++++++++
 tb/tb_brc_iter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/brc_iter.sv
// Iterative branch comparator: resolves BEQ/BNE/BLT/BGE/BLTU/BGEU over CHUNK_W-bit
// slices, MSB chunk first. Define BRC_ITER_EARLY_EXIT_EN to leave BUSY on the first mismatch.
module brc_iter #(
  parameter int DATA_W  = 32,
  parameter int CHUNK_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_rs1_data,
  input  logic [DATA_W-1:0] i_rs2_data,
  input  logic [2:0]        i_br_op,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_br_less,
  output logic              o_br_equal,
  output logic              o_br_taken,
  output logic              o_illegal
);

  localparam int N  = (CHUNK_W > 0) ? DATA_W / CHUNK_W : 1;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] LAST = KW'(N - 1);
  localparam logic [DATA_W-1:0] MSB = {1'b1, {(DATA_W-1){1'b0}}};
`ifdef BRC_ITER_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  if (CHUNK_W < 1) begin : g_bad_chunk
    $error("brc_iter: CHUNK_W must be >= 1");
  end else if (DATA_W % CHUNK_W != 0) begin : g_bad_div
    $error("brc_iter: DATA_W must be a multiple of CHUNK_W");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] a_r, b_r, a_nxt, b_nxt;
  logic [2:0]        op_r;
  logic [KW-1:0]     k;
  logic              diff, less_r;

  // Operands shift left so the chunk under test always sits in the top CHUNK_W bits.
  if (N > 1) begin : g_shift
    assign a_nxt = {a_r[DATA_W-CHUNK_W-1:0], {CHUNK_W{1'b0}}};
    assign b_nxt = {b_r[DATA_W-CHUNK_W-1:0], {CHUNK_W{1'b0}}};
  end else begin : g_noshift
    assign a_nxt = a_r;
    assign b_nxt = b_r;
  end

  logic [CHUNK_W-1:0] a_top, b_top;
  logic               mis, fin_less, fin_eq, fin_taken, ill;

  assign a_top    = a_r[DATA_W-1 -: CHUNK_W];
  assign b_top    = b_r[DATA_W-1 -: CHUNK_W];
  assign mis      = (a_top != b_top);
  assign fin_less = diff ? less_r : (mis && (a_top < b_top));
  assign fin_eq   = !diff && !mis;
  assign ill      = (op_r[2:1] == 2'b01);

  always_comb begin
    fin_taken = 1'b0;
    case (op_r)
      3'b000:         fin_taken = fin_eq;
      3'b001:         fin_taken = !fin_eq;
      3'b100, 3'b110: fin_taken = fin_less;
      3'b101, 3'b111: fin_taken = !fin_less;
      default:        fin_taken = 1'b0;
    endcase
  end

  assign o_ready = (state == IDLE);
  assign o_valid = (state == DONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      a_r        <= '0;
      b_r        <= '0;
      op_r       <= '0;
      k          <= '0;
      diff       <= 1'b0;
      less_r     <= 1'b0;
      o_br_less  <= 1'b0;
      o_br_equal <= 1'b0;
      o_br_taken <= 1'b0;
      o_illegal  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          // Flipping the sign bit maps two's complement order onto unsigned order.
          a_r    <= i_br_op[1] ? i_rs1_data : (i_rs1_data ^ MSB);
          b_r    <= i_br_op[1] ? i_rs2_data : (i_rs2_data ^ MSB);
          op_r   <= i_br_op;
          k      <= '0;
          diff   <= 1'b0;
          less_r <= 1'b0;
          state  <= BUSY;
        end
        BUSY: begin
          if (!diff && mis) begin
            diff   <= 1'b1;
            less_r <= (a_top < b_top);
          end
          a_r <= a_nxt;
          b_r <= b_nxt;
          k   <= k + KW'(1);
          if (k == LAST || (EARLY && mis)) begin
            o_br_less  <= fin_less;
            o_br_equal <= fin_eq;
            o_br_taken <= fin_taken && !ill;
            o_illegal  <= ill;
            state      <= DONE;
          end
        end
        DONE: if (i_ready) begin
          o_br_less  <= 1'b0;
          o_br_equal <= 1'b0;
          o_br_taken <= 1'b0;
          o_illegal  <= 1'b0;
          k          <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_brc_iter.sv
// Directed + random bench for brc_iter against an arithmetic branch-compare model.
module tb_brc_iter;
  localparam int DW = 32;
  localparam int CW = 8;
  localparam int N  = DW / CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0, i_ready = 1'b0;
  logic [DW-1:0] rs1 = '0, rs2 = '0;
  logic [2:0]    op = '0;
  logic          o_ready, o_valid, o_less, o_eq, o_taken, o_ill;

  int passed = 0;
  int total  = 0;

  brc_iter #(.DATA_W(DW), .CHUNK_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_rs1_data(rs1), .i_rs2_data(rs2), .i_br_op(op), .o_valid(o_valid),
    .i_ready(i_ready), .o_br_less(o_less), .o_br_equal(o_eq),
    .o_br_taken(o_taken), .o_illegal(o_ill)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: plain signed/unsigned arithmetic; latency from the first differing chunk.
  function automatic logic [3:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                       input logic [2:0] f);
    logic less, eq, tk, ill;
    ill  = (f == 3'b010) || (f == 3'b011);
    less = f[1] ? (a < b) : ($signed(a) < $signed(b));
    eq   = (a == b);
    case (f)
      3'b000:         tk = eq;
      3'b001:         tk = !eq;
      3'b100, 3'b110: tk = less;
      3'b101, 3'b111: tk = !less;
      default:        tk = 1'b0;
    endcase
    return {less, eq, tk, ill};
  endfunction

  function automatic int latency(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef BRC_ITER_EARLY_EXIT_EN
    logic [DW-1:0] x;
    x = a ^ b;
    for (int i = 0; i < N; i++)
      if (((x >> (DW - (i + 1) * CW)) & ((1 << CW) - 1)) != 0) return i + 1;
`endif
    return N;
  endfunction

  task automatic run(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                     input logic [2:0] f, input int hold);
    logic [3:0] exp;
    int cyc;
    exp = model(a, b, f);
    check({tag, ".rdy"}, 32'(o_ready), 32'd1);
    rs1 = a; rs2 = b; op = f; i_valid = 1'b1;
    @(posedge clk); #1;
    // Garbage on the inputs while busy must not disturb the result.
    rs1 = $urandom; rs2 = $urandom; op = 3'($urandom);
    cyc = 0;
    while (!o_valid && cyc < 20) begin
      total++;
      assert (o_ready === 1'b0 && {o_less, o_eq, o_taken, o_ill} === 4'b0) passed++;
      else $error("FAIL %s.busy: observed rdy=%b flags=%b expected rdy=0 flags=0",
                  tag, o_ready, {o_less, o_eq, o_taken, o_ill});
      @(posedge clk); #1;
      cyc++;
    end
    i_valid = 1'b0;
    check({tag, ".lat"}, 32'(cyc), 32'(latency(a, b)));
    check({tag, ".flags"}, 32'({o_less, o_eq, o_taken, o_ill}), 32'(exp));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, ".hold"}, 32'({o_valid, o_ready, o_less, o_eq, o_taken, o_ill}),
            32'({2'b10, exp}));
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    check({tag, ".post"}, 32'({o_valid, o_ready, o_less, o_eq, o_taken, o_ill}),
          32'(6'b010000));
  endtask

  initial begin
    logic [DW-1:0] a, b;
    logic [2:0]    f;
    #12;
    check("reset", 32'({o_valid, o_less, o_eq, o_taken, o_ill}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle", 32'({o_valid, o_ready}), 32'b01);

    run("blt_neg", 32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 0);
    run("bltu_big", 32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 0);
    run("beq_eq", 32'h1234_5678, 32'h1234_5678, 3'b000, 0);
    run("bge_min", 32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 1);
    run("bne_hold", 32'h0000_0100, 32'h0000_0200, 3'b001, 5);
    run("illegal", 32'h0000_0005, 32'h0000_0003, 3'b010, 0);
    run("illegal3", 32'h0000_0003, 32'h0000_0005, 3'b011, 0);
    run("bgeu_lsb", 32'hA5A5_A5A4, 32'hA5A5_A5A5, 3'b111, 0);

    // Reset mid-BUSY must drop the transaction.
    rs1 = 32'h1; rs2 = 32'h2; op = 3'b100; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_busy", 32'({o_valid, o_less, o_eq, o_taken, o_ill}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check("rst_after", 32'({o_valid, o_ready, o_less, o_eq, o_taken, o_ill}),
            32'(6'b010000));
    end

    for (int t = 0; t < 40; t++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ (32'(8'($urandom_range(1, 255))) << (8 * $urandom_range(0, 3)));
        2: b = a ^ 32'h8000_0000;
        default: b = $urandom;
      endcase
      f = 3'($urandom);
      run("rand", a, b, f, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
